mef_embalagem: RTL
==================

Name: mef_embalagem

Overview:
- Packing stage directly downstream of the dozen counter.
- Consumes one-cycle "dozen complete" pulses and buffers them as a pending-dozen count.
- Each pending dozen is loaded into one box through a box-feed / load / seal / release sequence.
- Drives the box conveyor, loading arm and sealer. Exposes pending and total-box counts in binary for the existing decimal display decoders.

Parameters:
- DEPTH, 4, maximum pending dozens held (1..15).
- CARGA_CICLOS, 3, clk cycles the loading arm stays active.
- LACRE_CICLOS, 2, clk cycles the sealer stays active.
- TIMEOUT, 8, clk cycles allowed for a box to arrive before fault.

Ports:
- clk  input  1  stage clock (divided system clock)
- reset  input  1  asynchronous, active-low reset
- habilita  input  1  line enable (mirrors start); low = stop accepting new boxes
- duzia_pronta  input  1  one-cycle pulse, one dozen released by the dozen counter
- caixa_presente  input  1  box sensor at loading position, level
- motor_caixa  output  1  box conveyor motor
- braco  output  1  loading arm actuator
- lacre  output  1  sealer actuator
- ocupado  output  1  high in any state other than OCIOSO
- cheio  output  1  pendentes == DEPTH
- overflow  output  1  sticky: a dozen was dropped
- falha  output  1  box-arrival timeout fault
- pendentes  output  4  pending dozens
- caixas_total  output  8  boxes completed, 0..99

Behaviour:
- Reset (reset=0, async): state OCIOSO; all outputs 0; pendentes=0; caixas_total=0; internal timer=0.
- All state, counters and registered outputs update on posedge clk. Outputs are registered (Moore).
- States and transitions:
  - OCIOSO: if habilita=1 and pendentes>0 -> BUSCA_CAIXA, timer cleared.
  - BUSCA_CAIXA: motor_caixa=1; timer++ each cycle.
    - caixa_presente=1 -> CARREGA, timer cleared.
    - Else timer==TIMEOUT-1 -> FALHA.
  - CARREGA: braco=1 for exactly CARGA_CICLOS cycles.
    - pendentes decrements once, on the transition into CARREGA.
    - Then -> LACRA.
  - LACRA: lacre=1 for exactly LACRE_CICLOS cycles -> LIBERA.
  - LIBERA: motor_caixa=1 until caixa_presente=0.
    - caixas_total increments on that cycle; 99 wraps to 0.
    - Then -> OCIOSO.
  - FALHA: falha=1, motor_caixa=0; held until habilita=0, then -> OCIOSO with falha cleared.
- habilita=0 mid-sequence: current box finishes (CARREGA/LACRA/LIBERA complete). habilita only gates the start of a new box.
- habilita=0 in BUSCA_CAIXA: return to OCIOSO. Nothing is consumed.
- Pending counter:
  - duzia_pronta increments pendentes in every state, including FALHA.
  - Increment and decrement in the same cycle: pendentes unchanged.
  - pendentes==DEPTH with duzia_pronta and no decrement: pulse dropped, pendentes stays DEPTH, overflow set.
  - overflow clears only on reset.
- cheio is combinational from the pendentes register.
- Latency: a duzia_pronta pulse in OCIOSO (habilita=1, box already present) gives pendentes=1 the next edge.
  - BUSCA_CAIXA is entered the edge after that.
  - CARREGA follows one cycle later.
- Box removed during CARREGA/LACRA: ignored. The sequence runs on timers only.

Test Plan:
- Single dozen, box present: duzia_pronta pulse, caixa_presente=1, dropped 2 cycles after LIBERA entry -> braco high 3 cycles, lacre high 2 cycles, caixas_total 0->1, pendentes 1->0, ocupado back to 0.
- Overflow: habilita=0, five duzia_pronta pulses with DEPTH=4 -> pendentes=4, cheio=1, overflow=1 after fifth pulse; then habilita=1 drains 4 boxes, overflow stays 1.
- Timeout: pendentes=1, habilita=1, caixa_presente held 0 -> falha=1 after 8 cycles in BUSCA_CAIXA, motor_caixa=0, pendentes still 1; habilita=0 -> OCIOSO, falha=0.
- Simultaneous: duzia_pronta asserted on the cycle OCIOSO/BUSCA_CAIXA -> CARREGA with pendentes=2 -> pendentes remains 2.
- Wrap: preload 99 boxes via repeated sequences -> next box gives caixas_total=0.
- Async reset asserted in LACRA -> immediately lacre=0, state OCIOSO, pendentes=0, caixas_total=0, overflow=0.

Source files
------------

// File: rtl/mef_embalagem_if.sv
// Packing-stage signal bundle: line/counter/sensor inputs, actuator and status outputs.
// Plain wires; the master drives the inputs and the stage drives everything else.
interface mef_embalagem_if;
   logic       habilita;
   logic       duzia_pronta;
   logic       caixa_presente;
   logic       motor_caixa;
   logic       braco;
   logic       lacre;
   logic       ocupado;
   logic       cheio;
   logic       overflow;
   logic       falha;
   logic [3:0] pendentes;
   logic [7:0] caixas_total;

   modport master (
      output habilita, duzia_pronta, caixa_presente,
      input  motor_caixa, braco, lacre, ocupado, cheio, overflow, falha,
             pendentes, caixas_total
   );

   modport slave (
      input  habilita, duzia_pronta, caixa_presente,
      output motor_caixa, braco, lacre, ocupado, cheio, overflow, falha,
             pendentes, caixas_total
   );
endinterface

// File: rtl/mef_embalagem.sv
// Packing FSM: buffers dozen pulses and boxes each one (feed/load/seal/release), Moore outputs registered.
// Latency: pulse -> pendentes +1 next edge, BUSCA_CAIXA one edge later; no backpressure, overflowing pulses are dropped.
module mef_embalagem #(
   parameter int DEPTH        = 4,
   parameter int CARGA_CICLOS = 3,
   parameter int LACRE_CICLOS = 2,
   parameter int TIMEOUT      = 8
) (
   input logic            clk,
   input logic            reset,
   mef_embalagem_if.slave bus
);

   typedef enum logic [2:0] {
      OCIOSO,
      BUSCA_CAIXA,
      CARREGA,
      LACRA,
      LIBERA,
      FALHA
   } estado_t;

   estado_t    estado, prox;
   logic [7:0] timer, timer_prox;
   logic       consome;
   logic       conclui;
   logic [3:0] pendentes;
   logic [7:0] caixas_total;
   logic       overflow;

   always_comb begin
      prox       = estado;
      timer_prox = timer;
      consome    = 1'b0;
      conclui    = 1'b0;
      case (estado)
         OCIOSO: begin
            if (bus.habilita && (pendentes != 4'd0)) begin
               prox       = BUSCA_CAIXA;
               timer_prox = '0;
            end
         end
         BUSCA_CAIXA: begin
            // Losing the line enable aborts the search before anything is consumed.
            if (!bus.habilita) begin
               prox       = OCIOSO;
               timer_prox = '0;
            end else if (bus.caixa_presente) begin
               prox       = CARREGA;
               timer_prox = '0;
               consome    = 1'b1;
            end else if (timer == 8'(TIMEOUT - 1)) begin
               prox       = FALHA;
               timer_prox = '0;
            end else begin
               timer_prox = timer + 8'd1;
            end
         end
         CARREGA: begin
            if (timer == 8'(CARGA_CICLOS - 1)) begin
               prox       = LACRA;
               timer_prox = '0;
            end else begin
               timer_prox = timer + 8'd1;
            end
         end
         LACRA: begin
            if (timer == 8'(LACRE_CICLOS - 1)) begin
               prox       = LIBERA;
               timer_prox = '0;
            end else begin
               timer_prox = timer + 8'd1;
            end
         end
         LIBERA: begin
            if (!bus.caixa_presente) begin
               prox    = OCIOSO;
               conclui = 1'b1;
            end
         end
         FALHA: begin
            if (!bus.habilita) begin
               prox = OCIOSO;
            end
         end
         default: begin
            prox       = OCIOSO;
            timer_prox = '0;
         end
      endcase
   end

   // Actuator outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado          <= OCIOSO;
         timer           <= '0;
         bus.motor_caixa <= 1'b0;
         bus.braco       <= 1'b0;
         bus.lacre       <= 1'b0;
         bus.falha       <= 1'b0;
         bus.ocupado     <= 1'b0;
      end else begin
         estado          <= prox;
         timer           <= timer_prox;
         bus.motor_caixa <= (prox == BUSCA_CAIXA) || (prox == LIBERA);
         bus.braco       <= (prox == CARREGA);
         bus.lacre       <= (prox == LACRA);
         bus.falha       <= (prox == FALHA);
         bus.ocupado     <= (prox != OCIOSO);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pendentes <= '0;
         overflow  <= 1'b0;
      end else begin
         case ({bus.duzia_pronta, consome})
            2'b10: begin
               if (pendentes == 4'(DEPTH)) begin
                  overflow <= 1'b1;
               end else begin
                  pendentes <= pendentes + 4'd1;
               end
            end
            2'b01:   pendentes <= pendentes - 4'd1;
            default: pendentes <= pendentes;
         endcase
      end
   end

   // Box count feeds a two-digit decimal display, hence the wrap at 99.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         caixas_total <= '0;
      end else if (conclui) begin
         caixas_total <= (caixas_total == 8'd99) ? 8'd0 : caixas_total + 8'd1;
      end
   end

   assign bus.pendentes    = pendentes;
   assign bus.caixas_total = caixas_total;
   assign bus.overflow     = overflow;
   assign bus.cheio        = (pendentes == 4'(DEPTH));

endmodule
